br_ckpt_stack_nw: RTL

- N-wide successor to the single-branch checkpoint stack: allocates up to N branch checkpoints per cycle, in slot order.
- Tracks one-hot branch ids and dependency masks for every live branch.
- Resolves CLEAR and SQUASH from the branch unit; SQUASH returns the recovery checkpoint one cycle later through a registered port.
- Sits between dispatch and the map table / free list / ROB / SQ recovery logic.
- Checkpoint payload is opaque here (packed map table, fl_head, rob_tail, sq_tail, built by the caller).

---
 rtl/br_ckpt_stack_nw.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/br_ckpt_stack_nw.sv
// N-wide branch checkpoint stack: allocates up to N one-hot branch ids per cycle and resolves CLEAR/SQUASH.
// Optional perf counters are built when BR_CKPT_PERF_EN is defined.
module br_ckpt_stack_nw #(
  parameter int DEPTH = 8,
  parameter int N     = 2,
  parameter int CP_W  = 128
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N-1:0]               dis_valid,
  input  logic [N*CP_W-1:0]          dis_cp,
  output logic                       dis_stall,
  output logic [N*DEPTH-1:0]         dis_b_id,
  output logic [N*DEPTH-1:0]         dis_b_mask,
  input  logic [1:0]                 br_task,
  input  logic [DEPTH-1:0]           rem_b_id,
  output logic                       cp_valid,
  output logic [CP_W-1:0]            cp_out,
  output logic [DEPTH-1:0]           live_mask,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt,
  output logic                       full
`ifdef BR_CKPT_PERF_EN
  ,
  output logic [31:0]                perf_squash_cnt,
  output logic [31:0]                perf_clear_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] TASK_CLEAR  = 2'd1;
  localparam logic [1:0] TASK_SQUASH = 2'd2;

  logic [DEPTH-1:0] b_mask  [DEPTH];
  logic [CP_W-1:0]  payload [DEPTH];

  logic             hit, do_clear, do_squash;
  logic [IW-1:0]    rem_idx;
  logic [CW-1:0]    req_cnt, live_cnt, free_next;
  logic [DEPTH-1:0] alloc_we, kill, live_next, taken, acc, grant, base;
  logic [DEPTH-1:0] ent_mask [DEPTH];
  logic [CP_W-1:0]  ent_cp   [DEPTH];
  logic             found;

  assign hit       = |(rem_b_id & live_mask);
  assign do_clear  = (br_task == TASK_CLEAR)  && hit;
  assign do_squash = (br_task == TASK_SQUASH) && hit;
  assign full      = free_cnt < CW'(N);
  assign dis_stall = (req_cnt > free_cnt) || (br_task == TASK_SQUASH);

  always_comb begin
    req_cnt = '0;
    for (int k = 0; k < N; k++) req_cnt = req_cnt + CW'(dis_valid[k]);
    rem_idx = '0;
    for (int i = 0; i < DEPTH; i++) if (rem_b_id[i]) rem_idx = IW'(i);
  end

  // The allocator only sees the pre-clear free set; masks exclude the bit being cleared.
  always_comb begin
    taken      = '0;
    acc        = '0;
    alloc_we   = '0;
    dis_b_id   = '0;
    dis_b_mask = '0;
    base       = live_mask & ~(do_clear ? rem_b_id : '0);
    for (int i = 0; i < DEPTH; i++) begin
      ent_mask[i] = '0;
      ent_cp[i]   = '0;
    end
    for (int k = 0; k < N; k++) begin
      grant = '0;
      found = 1'b0;
      if (!dis_stall && dis_valid[k]) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!found && !live_mask[i] && !taken[i]) begin
            found    = 1'b1;
            taken[i] = 1'b1;
            grant[i] = 1'b1;
          end
        end
      end
      acc = acc | grant;
      dis_b_id[k*DEPTH +: DEPTH]   = grant;
      dis_b_mask[k*DEPTH +: DEPTH] = base | acc;
      for (int i = 0; i < DEPTH; i++) begin
        if (grant[i]) begin
          alloc_we[i] = 1'b1;
          ent_mask[i] = base | acc;
          ent_cp[i]   = dis_cp[k*CP_W +: CP_W];
        end
      end
    end
  end

  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_clear && rem_b_id[i]) kill[i] = 1'b1;
      if (do_squash && (rem_b_id[i] || |(b_mask[i] & rem_b_id))) kill[i] = 1'b1;
    end
    live_next = (live_mask & ~kill) | alloc_we;
    live_cnt  = '0;
    for (int i = 0; i < DEPTH; i++) live_cnt = live_cnt + CW'(live_next[i]);
    free_next = CW'(DEPTH) - live_cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live_mask <= '0;
      free_cnt  <= CW'(DEPTH);
      cp_valid  <= 1'b0;
      cp_out    <= '0;
      for (int i = 0; i < DEPTH; i++) b_mask[i] <= '0;
    end else begin
      live_mask <= live_next;
      free_cnt  <= free_next;
      cp_valid  <= do_squash;
      if (do_squash) cp_out <= payload[rem_idx];
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_we[i])   b_mask[i] <= ent_mask[i];
        else if (do_clear) b_mask[i] <= b_mask[i] & ~rem_b_id;
      end
    end
  end

  // Payload is only meaningful while the entry is live, so it needs no reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) if (alloc_we[i]) payload[i] <= ent_cp[i];
  end

`ifdef BR_CKPT_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_squash_cnt <= '0;
      perf_clear_cnt  <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (do_squash && perf_squash_cnt != '1) perf_squash_cnt <= perf_squash_cnt + 32'd1;
      if (do_clear && perf_clear_cnt != '1)   perf_clear_cnt  <= perf_clear_cnt + 32'd1;
      if (dis_stall && |dis_valid && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule
